// File: rtl/id_ex_issue_buffer_pkg.sv
// Shared widths, funct codes and payload helpers for the ID->EX issue buffer.
package id_ex_issue_buffer_pkg;

    // Default bus widths
    localparam int DATA_BUS      = 32;
    localparam int FUNCT_BUS     = 6;
    localparam int SHAMT_BUS     = 5;
    localparam int REG_ADDR_BUS  = 5;
    localparam int STALL_CNT_BUS = 16;

    // funct, logic_en, operand_1, operand_2, shamt, wb_en, wb_addr
    localparam int ISSUE_PAYLOAD_W =
        FUNCT_BUS + 1 + DATA_BUS + DATA_BUS + SHAMT_BUS + 1 + REG_ADDR_BUS;

    // funct codes travel through this block untouched; listed for reference
    localparam logic [FUNCT_BUS-1:0] FUNCT_SLL = 6'h00;
    localparam logic [FUNCT_BUS-1:0] FUNCT_SRL = 6'h02;
    localparam logic [FUNCT_BUS-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_BUS-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_BUS-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_BUS-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_BUS-1:0] FUNCT_XOR = 6'h26;
    localparam logic [FUNCT_BUS-1:0] FUNCT_NOR = 6'h27;

    // Payload width for a non-default parameter set
    function automatic int issue_payload_w(input int data_w, input int funct_w,
                                           input int shamt_w, input int reg_addr_w);
        return funct_w + 1 + (2 * data_w) + shamt_w + 1 + reg_addr_w;
    endfunction

endpackage

// File: rtl/id_ex_issue_buffer_if.sv
// ID->EX operation interface: valid/ready handshake on the ID side and the
// gated operation payload on the EX side.
interface id_ex_issue_buffer_if
    import id_ex_issue_buffer_pkg::*;
#(
    parameter int DATA_W     = DATA_BUS,
    parameter int FUNCT_W    = FUNCT_BUS,
    parameter int SHAMT_W    = SHAMT_BUS,
    parameter int REG_ADDR_W = REG_ADDR_BUS
);

    // ID side
    logic                  id_valid;
    logic                  id_ready;
    logic [FUNCT_W-1:0]    id_funct;
    logic                  id_logic_en;
    logic [DATA_W-1:0]     id_operand_1;
    logic [DATA_W-1:0]     id_operand_2;
    logic [SHAMT_W-1:0]    id_shamt;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_wb_addr;

    // EX side
    logic                  ex_valid;
    logic                  ex_ready;
    logic [FUNCT_W-1:0]    ex_funct;
    logic                  ex_logic_en;
    logic [DATA_W-1:0]     ex_operand_1;
    logic [DATA_W-1:0]     ex_operand_2;
    logic [SHAMT_W-1:0]    ex_shamt;
    logic                  ex_wb_en;
    logic [REG_ADDR_W-1:0] ex_wb_addr;

    // The issue buffer itself
    modport slave (
        input  id_valid, id_funct, id_logic_en, id_operand_1, id_operand_2,
               id_shamt, id_wb_en, id_wb_addr, ex_ready,
        output id_ready, ex_valid, ex_funct, ex_logic_en, ex_operand_1,
               ex_operand_2, ex_shamt, ex_wb_en, ex_wb_addr
    );

    // The surroundings: ID drives operations, EX drives ready
    modport master (
        output id_valid, id_funct, id_logic_en, id_operand_1, id_operand_2,
               id_shamt, id_wb_en, id_wb_addr, ex_ready,
        input  id_ready, ex_valid, ex_funct, ex_logic_en, ex_operand_1,
               ex_operand_2, ex_shamt, ex_wb_en, ex_wb_addr
    );

endinterface

// File: rtl/id_ex_issue_buffer_issue_slot.sv
// One buffer entry: a valid flag and a payload register.
// Clear wins over load; a cleared slot also zeroes its payload so nothing
// stale is ever left sitting in an empty entry.
module id_ex_issue_buffer_issue_slot
    import id_ex_issue_buffer_pkg::*;
#(
    parameter int W = ISSUE_PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Slot state: clear empties, load captures a new operation, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/id_ex_issue_buffer.sv
// ID->EX issue buffer: 2-entry skid buffer between decode and the EX units.
// id_ready comes straight from the skid flag register, so there is no
// combinational path from ex_ready back to ID. The main slot feeds EX; the
// skid slot catches the one operation that can arrive while EX stalls.
module id_ex_issue_buffer
    import id_ex_issue_buffer_pkg::*;
#(
    parameter int DATA_W     = DATA_BUS,
    parameter int FUNCT_W    = FUNCT_BUS,
    parameter int SHAMT_W    = SHAMT_BUS,
    parameter int REG_ADDR_W = REG_ADDR_BUS,
    parameter int CNT_W      = STALL_CNT_BUS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall_cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    id_ex_issue_buffer_if.slave bus
);

    localparam int PW = issue_payload_w(DATA_W, FUNCT_W, SHAMT_W, REG_ADDR_W);

    logic [PW-1:0]    w_id_payload;
    logic [PW-1:0]    w_ex_payload;
    logic [PW-1:0]    w_main_data;
    logic [PW-1:0]    w_main_next;
    logic [PW-1:0]    w_skid_data;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic             w_accept;
    logic             w_issue;
    logic             w_stall;
    logic             w_main_load;
    logic             w_main_clear;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_id_payload = {bus.id_funct, bus.id_logic_en, bus.id_operand_1,
                           bus.id_operand_2, bus.id_shamt, bus.id_wb_en,
                           bus.id_wb_addr};

    // id_ready is the inverted skid flag, itself a register
    assign bus.id_ready = ~w_skid_valid;
    assign w_accept     = bus.id_valid & ~w_skid_valid;
    assign w_issue      = w_main_valid & bus.ex_ready;
    assign w_stall      = w_main_valid & ~bus.ex_ready;

    // The older operation always refills main first
    assign w_main_next  = w_skid_valid ? w_skid_data : w_id_payload;

    // Slot control: flush empties both; otherwise main refills whenever it
    // is empty or draining, and skid only catches an accept while main stalls
    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (!w_main_valid || w_issue) begin
            if (w_skid_valid) begin
                // id_ready is low here, so nothing can be accepted this cycle
                w_main_load  = 1'b1;
                w_skid_clear = 1'b1;
            end else if (w_accept) begin
                w_main_load  = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else if (w_accept) begin
            w_skid_load = 1'b1;
        end
    end

    id_ex_issue_buffer_issue_slot #(
        .W (PW)
    ) u_main_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_next),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    id_ex_issue_buffer_issue_slot #(
        .W (PW)
    ) u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_id_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // EX payload is forced to zero whenever there is no valid operation, so
    // the logic unit sees logic_en=0 and produces a zero result
    assign w_ex_payload = w_main_valid ? w_main_data : '0;
    assign bus.ex_valid = w_main_valid;
    assign {bus.ex_funct, bus.ex_logic_en, bus.ex_operand_1, bus.ex_operand_2,
            bus.ex_shamt, bus.ex_wb_en, bus.ex_wb_addr} = w_ex_payload;

    // Stall counter: clear wins, otherwise count stalled cycles up to all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_issue_buffer.sv
// Bench for id_ex_issue_buffer. The reference model is a plain queue of
// buffered operations (at most two) plus a saturating integer counter.
module tb_id_ex_issue_buffer;
    import id_ex_issue_buffer_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [5:0]  funct;
        logic        logic_en;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  shamt;
        logic        wb_en;
        logic [4:0]  wb_addr;
    } op_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             stall_cnt_clr = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    op_t q[$];
    int  m_cnt = 0;

    id_ex_issue_buffer_if #(
        .DATA_W(32), .FUNCT_W(6), .SHAMT_W(5), .REG_ADDR_W(5)
    ) bus ();

    id_ex_issue_buffer #(
        .DATA_W(32), .FUNCT_W(6), .SHAMT_W(5), .REG_ADDR_W(5), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t ex_obs();
        op_t o;
        o = {bus.ex_funct, bus.ex_logic_en, bus.ex_operand_1, bus.ex_operand_2,
             bus.ex_shamt, bus.ex_wb_en, bus.ex_wb_addr};
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.funct    = 6'($urandom);
        o.logic_en = 1'($urandom);
        o.op1      = $urandom;
        o.op2      = $urandom;
        o.shamt    = 5'($urandom);
        o.wb_en    = 1'($urandom);
        o.wb_addr  = 5'($urandom);
        return o;
    endfunction

    task automatic check_outputs();
        op_t exp_p;
        exp_p = (q.size() > 0) ? q[0] : '0;
        chk("ex_valid",  128'(bus.ex_valid), 128'(q.size() > 0));
        chk("id_ready",  128'(bus.id_ready), 128'(q.size() < 2));
        chk("stall_cnt", 128'(stall_cnt),    128'(m_cnt));
        chk("payload",   128'(ex_obs()),     128'(exp_p));
    endtask

    // Called on a falling edge: check, drive, advance the model, and return
    // on the next falling edge.
    task automatic step(input logic v, input op_t op, input logic rdy,
                        input logic fl, input logic clr);
        int  n;
        logic acc, iss;
        check_outputs();
        bus.id_valid     = v;
        bus.id_funct     = op.funct;
        bus.id_logic_en  = op.logic_en;
        bus.id_operand_1 = op.op1;
        bus.id_operand_2 = op.op2;
        bus.id_shamt     = op.shamt;
        bus.id_wb_en     = op.wb_en;
        bus.id_wb_addr   = op.wb_addr;
        bus.ex_ready     = rdy;
        flush            = fl;
        stall_cnt_clr    = clr;
        n   = q.size();
        acc = v && (n < 2);
        iss = (n > 0) && rdy;
        if (clr) m_cnt = 0;
        else if (n > 0 && !rdy && m_cnt < CNT_MAX) m_cnt++;
        if (fl) q.delete();
        else begin
            if (iss) void'(q.pop_front());
            if (acc) q.push_back(op);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        op_t op_a, op1, op2, op3, nul;
        nul = '0;
        bus.id_valid = 1'b0; bus.id_funct = '0; bus.id_logic_en = 1'b0;
        bus.id_operand_1 = '0; bus.id_operand_2 = '0; bus.id_shamt = '0;
        bus.id_wb_en = 1'b0; bus.id_wb_addr = '0; bus.ex_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Single op with 1-cycle latency, then gated-to-zero payload
        op_a = '{funct: FUNCT_AND, logic_en: 1'b1, op1: 32'hF0F0_F0F0,
                 op2: 32'hFF00_FF00, shamt: 5'd0, wb_en: 1'b1, wb_addr: 5'd3};
        step(1'b1, op_a, 1'b1, 1'b0, 1'b0);
        chk("single_ex_valid", 128'(bus.ex_valid), 128'(1));
        chk("single_payload",  128'(ex_obs()),     128'(op_a));
        step(1'b0, nul, 1'b1, 1'b0, 1'b0);
        chk("single_gated", 128'({bus.ex_valid, ex_obs()}), 128'(0));

        // Back-pressure: three ops offered while EX stalls
        op1 = rand_op(); op2 = rand_op(); op3 = rand_op();
        step(1'b1, op1, 1'b0, 1'b0, 1'b0);
        step(1'b1, op2, 1'b0, 1'b0, 1'b0);
        chk("bp_id_ready_low", 128'(bus.id_ready), 128'(0));
        step(1'b1, op3, 1'b0, 1'b0, 1'b0);
        step(1'b1, op3, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_op1", 128'(ex_obs()), 128'(op1));
        step(1'b1, op3, 1'b1, 1'b0, 1'b0);
        chk("bp_second", 128'(ex_obs()), 128'(op2));
        step(1'b1, op3, 1'b1, 1'b0, 1'b0);
        chk("bp_third", 128'(ex_obs()), 128'(op3));
        step(1'b0, nul, 1'b1, 1'b0, 1'b0);
        chk("bp_stalls", 128'(stall_cnt), 128'(3));
        step(1'b0, nul, 1'b1, 1'b0, 1'b1);

        // Streaming: 100 ops, ex_ready held high
        for (int i = 0; i < 100; i++) step(1'b1, rand_op(), 1'b1, 1'b0, 1'b0);
        step(1'b0, nul, 1'b1, 1'b0, 1'b0);

        // Flush with both slots full and a new op offered
        step(1'b1, rand_op(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_op(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_op(), 1'b0, 1'b1, 1'b0);
        chk("flush_ex_valid", 128'(bus.ex_valid), 128'(0));
        chk("flush_id_ready", 128'(bus.id_ready), 128'(1));
        for (int i = 0; i < 3; i++) step(1'b0, nul, 1'b1, 1'b0, 1'b0);

        // Counter saturation, then clear during the stall
        step(1'b0, nul, 1'b1, 1'b0, 1'b1);
        step(1'b1, rand_op(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, nul, 1'b0, 1'b0, 1'b0);
        chk("cnt_saturated", 128'(stall_cnt), 128'(CNT_MAX));
        step(1'b0, nul, 1'b0, 1'b0, 1'b1);
        chk("cnt_cleared", 128'(stall_cnt), 128'(0));
        step(1'b0, nul, 1'b0, 1'b0, 1'b0);
        step(1'b0, nul, 1'b0, 1'b0, 1'b0);
        chk("cnt_resumed", 128'(stall_cnt), 128'(2));

        // Asynchronous reset in the middle of the stall
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", 128'(bus.ex_valid), 128'(0));
        chk("arst_id_ready", 128'(bus.id_ready), 128'(1));
        chk("arst_stall_cnt", 128'(stall_cnt), 128'(0));
        chk("arst_payload", 128'(ex_obs()), 128'(0));
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random mix of offers, back-pressure, flushes and clears
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_op(),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 39) == 0));
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
